// File: rtl/mu0_pkg.sv
// mu0_pkg: shared opcode, ALU function, state and control-vector types for the MU0 sequencer
package mu0_pkg;
  typedef enum logic [3:0] {LDA = 4'h0, STO, ADD, SUB, JMP, JGE, JNE, STP} opcode_t;
  typedef enum logic [1:0] {ALU_Y, ALU_ADD, ALU_SUB, ALU_INC} alu_fn_t;
  typedef enum logic [1:0] {FETCH, EXEC, HALT, FAULT} state_t;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'h8;
  typedef struct packed {
    logic    mem_req;
    logic    rd;
    logic    wr;
    logic    asel;
    logic    xsel;
    logic    ysel;
    alu_fn_t alu_fn;
    logic    pc_en;
    logic    ir_en;
    logic    acc_en;
  } ctrl_t;
endpackage

// File: rtl/mu0_ctrl_decode.sv
// mu0_ctrl_decode: opcode to control-vector decode for the EXEC state
module mu0_ctrl_decode
  import mu0_pkg::*;
(
  input  logic [3:0] i_f,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_mem_ack,
  output ctrl_t      o_ctrl,
  output logic       o_done,
  output logic       o_halt,
  output logic       o_illegal
);
  always_comb begin
    o_ctrl = '0;
    o_done = 1'b0;
    o_halt = 1'b0;
    o_illegal = i_f >= OP_ILLEGAL_MIN;
    case (i_f)
      LDA, ADD, SUB: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.rd = 1'b1;
        o_ctrl.asel = 1'b1;
        o_ctrl.alu_fn = i_f == ADD ? ALU_ADD : i_f == SUB ? ALU_SUB : ALU_Y;
        o_ctrl.acc_en = i_mem_ack;
        o_done = i_mem_ack;
      end
      STO: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.wr = 1'b1;
        o_ctrl.asel = 1'b1;
        o_done = i_mem_ack;
      end
      JMP, JGE, JNE: begin
        o_ctrl.ysel = 1'b1;
        o_ctrl.alu_fn = ALU_Y;
        o_ctrl.pc_en = i_f == JGE ? ~i_n : i_f == JNE ? ~i_z : 1'b1;
        o_done = 1'b1;
      end
      STP: begin
        o_halt = 1'b1;
        o_done = 1'b1;
      end
      default: o_done = 1'b0;
    endcase
  end
endmodule

// File: rtl/mu0_control.sv
// mu0_control: multi-cycle fetch/execute sequencer for the MU0 datapath
// with memory-timeout fault detection and saturating debug counters.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             MemAck,
  output logic             MemReq,
  output logic             Rd,
  output logic             Wr,
  output logic             ASel,
  output logic             XSel,
  output logic             YSel,
  output logic [1:0]       AluFn,
  output logic             PC_En,
  output logic             IR_En,
  output logic             ACC_En,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);
  state_t           r_state, w_next;
  ctrl_t            w_ctrl, w_dec;
  logic             w_done, w_halt, w_illegal, w_timeout, w_active;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_cycle, r_instr;

  mu0_ctrl_decode u_dec (
    .i_f       (F),
    .i_n       (N),
    .i_z       (Z),
    .i_mem_ack (MemAck),
    .o_ctrl    (w_dec),
    .o_done    (w_done),
    .o_halt    (w_halt),
    .o_illegal (w_illegal)
  );

  // controls are gated by nReset so an abandoned access drops at once
  always_comb begin
    w_ctrl = '0;
    if (nReset && r_state == FETCH) begin
      w_ctrl.mem_req = 1'b1;
      w_ctrl.rd = 1'b1;
      w_ctrl.xsel = 1'b1;
      w_ctrl.alu_fn = ALU_INC;
      w_ctrl.pc_en = MemAck;
      w_ctrl.ir_en = MemAck;
    end else if (nReset && r_state == EXEC) begin
      w_ctrl = w_dec;
    end
  end

  assign w_timeout = w_ctrl.mem_req && !MemAck && r_wait == 8'(MAX_WAIT - 1);
  assign w_active  = r_state == FETCH || r_state == EXEC;

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = MemAck ? EXEC : w_timeout ? FAULT : FETCH;
      EXEC:    w_next = w_illegal ? FAULT : w_halt ? HALT : w_done ? FETCH : w_timeout ? FAULT : EXEC;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_cycle <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_next != r_state ? '0 : (w_ctrl.mem_req && !MemAck) ? r_wait + 8'd1 : r_wait;
      if (w_active && r_cycle != '1) r_cycle <= r_cycle + CNT_W'(1);
      if (r_state == EXEC && w_done && r_instr != '1) r_instr <= r_instr + CNT_W'(1);
    end
  end

  assign MemReq     = w_ctrl.mem_req;
  assign Rd         = w_ctrl.rd;
  assign Wr         = w_ctrl.wr;
  assign ASel       = w_ctrl.asel;
  assign XSel       = w_ctrl.xsel;
  assign YSel       = w_ctrl.ysel;
  assign AluFn      = w_ctrl.alu_fn;
  assign PC_En      = w_ctrl.pc_en;
  assign IR_En      = w_ctrl.ir_en;
  assign ACC_En     = w_ctrl.acc_en;
  assign Halted     = r_state == HALT;
  assign Fault      = r_state == FAULT;
  assign CycleCount = r_cycle;
  assign InstrCount = r_instr;
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: directed checks of the MU0 sequencer against hand-computed control vectors
module tb_mu0_control;
  logic        Clk = 1'b0, nReset = 1'b0, N = 1'b0, Z = 1'b0, MemAck = 1'b0;
  logic [3:0]  F = 4'h0;
  logic        MemReq, Rd, Wr, ASel, XSel, YSel, PC_En, IR_En, ACC_En, Halted, Fault;
  logic [1:0]  AluFn;
  logic [15:0] CycleCount, InstrCount;
  int          errors = 0, checks = 0;

  // vector order: MemReq Rd Wr ASel XSel YSel | AluFn | PC_En IR_En ACC_En
  localparam logic [10:0] V_FETCH_ACK  = 11'b110010_11_110;
  localparam logic [10:0] V_FETCH_WAIT = 11'b110010_11_000;
  localparam logic [10:0] V_LDA_ACK    = 11'b110100_00_001;
  localparam logic [10:0] V_LDA_WAIT   = 11'b110100_00_000;
  localparam logic [10:0] V_ADD_ACK    = 11'b110100_01_001;
  localparam logic [10:0] V_STO_ACK    = 11'b101100_00_000;
  localparam logic [10:0] V_JMP_NOLD   = 11'b000001_00_000;
  localparam logic [10:0] V_JMP_LOAD   = 11'b000001_00_100;
  localparam logic [10:0] V_IDLE       = 11'b000000_00_000;

  always #5 Clk = ~Clk;

  mu0_control #(.MAX_WAIT(15), .CNT_W(16)) dut (
    .Clk(Clk), .nReset(nReset), .F(F), .N(N), .Z(Z), .MemAck(MemAck),
    .MemReq(MemReq), .Rd(Rd), .Wr(Wr), .ASel(ASel), .XSel(XSel), .YSel(YSel),
    .AluFn(AluFn), .PC_En(PC_En), .IR_En(IR_En), .ACC_En(ACC_En),
    .Halted(Halted), .Fault(Fault), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] f, input logic ack, input logic [10:0] exp);
    F = f;
    MemAck = ack;
    #1;
    chk(tag, {MemReq, Rd, Wr, ASel, XSel, YSel, AluFn, PC_En, IR_En, ACC_En}, exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    @(posedge Clk);
    #2;
    nReset = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_vec", {MemReq, Rd, Wr, ASel, XSel, YSel, AluFn, PC_En, IR_En, ACC_En}, V_IDLE);
    chk("rst_flags", {Halted, Fault}, 0);
    chk("rst_counts", {CycleCount, InstrCount}, 0);
    do_reset();
    // program LDA / ADD / STO / STP with MemAck held high
    step("f_lda", 4'h0, 1'b1, V_FETCH_ACK);
    step("x_lda", 4'h0, 1'b1, V_LDA_ACK);
    step("f_add", 4'h2, 1'b1, V_FETCH_ACK);
    step("x_add", 4'h2, 1'b1, V_ADD_ACK);
    step("f_sto", 4'h1, 1'b1, V_FETCH_ACK);
    step("x_sto", 4'h1, 1'b1, V_STO_ACK);
    step("f_stp", 4'h7, 1'b1, V_FETCH_ACK);
    chk("stp_not_yet_halted", Halted, 0);
    step("x_stp", 4'h7, 1'b1, V_IDLE);
    chk("halted", Halted, 1);
    chk("halt_fault", Fault, 0);
    chk("prog_cycles", CycleCount, 8);
    chk("prog_instrs", InstrCount, 4);
    step("halt_idle", 4'h0, 1'b1, V_IDLE);
    chk("halt_frozen_cycles", CycleCount, 8);
    chk("halt_frozen_instrs", InstrCount, 4);
    // conditional jumps
    do_reset();
    N = 1'b1;
    step("f_jge1", 4'h5, 1'b1, V_FETCH_ACK);
    step("x_jge_n1", 4'h5, 1'b1, V_JMP_NOLD);
    N = 1'b0;
    step("f_jge0", 4'h5, 1'b1, V_FETCH_ACK);
    step("x_jge_n0", 4'h5, 1'b1, V_JMP_LOAD);
    Z = 1'b1;
    step("f_jne1", 4'h6, 1'b1, V_FETCH_ACK);
    step("x_jne_z1", 4'h6, 1'b1, V_JMP_NOLD);
    Z = 1'b0;
    step("f_jne0", 4'h6, 1'b1, V_FETCH_ACK);
    step("x_jne_z0", 4'h6, 1'b1, V_JMP_LOAD);
    chk("jmp_cycles", CycleCount, 8);
    chk("jmp_instrs", InstrCount, 4);
    // LDA with MemAck delayed three cycles
    step("f_lda_slow", 4'h0, 1'b1, V_FETCH_ACK);
    chk("slow_entry_cycles", CycleCount, 9);
    for (int i = 0; i < 3; i++) step("x_lda_wait", 4'h0, 1'b0, V_LDA_WAIT);
    step("x_lda_late_ack", 4'h0, 1'b1, V_LDA_ACK);
    chk("slow_exit_cycles", CycleCount, 13);
    chk("slow_instrs", InstrCount, 5);
    // fetch that is never acknowledged
    for (int i = 0; i < 15; i++) begin
      chk("timeout_no_fault_yet", Fault, 0);
      step("timeout_fetch", 4'h0, 1'b0, V_FETCH_WAIT);
    end
    chk("timeout_fault", Fault, 1);
    chk("timeout_halted", Halted, 0);
    chk("timeout_cycles", CycleCount, 28);
    chk("timeout_instrs", InstrCount, 5);
    step("fault_idle", 4'h0, 1'b1, V_IDLE);
    chk("fault_frozen_cycles", CycleCount, 28);
    // illegal opcode
    do_reset();
    step("f_ill", 4'hA, 1'b1, V_FETCH_ACK);
    step("x_ill", 4'hA, 1'b1, V_IDLE);
    chk("ill_fault", Fault, 1);
    chk("ill_instrs", InstrCount, 0);
    chk("ill_cycles", CycleCount, 2);
    // reset in the middle of a fetch wait
    do_reset();
    for (int i = 0; i < 3; i++) step("pre_rst_wait", 4'h0, 1'b0, V_FETCH_WAIT);
    nReset = 1'b0;
    #1;
    chk("midrst_vec", {MemReq, Rd, Wr, ASel, XSel, YSel, AluFn, PC_En, IR_En, ACC_En}, V_IDLE);
    chk("midrst_counts", {CycleCount, InstrCount}, 0);
    #2;
    nReset = 1'b1;
    #1;
    chk("post_rst_counts", {CycleCount, InstrCount}, 0);
    chk("post_rst_flags", {Halted, Fault}, 0);
    step("post_rst_fetch", 4'h0, 1'b0, V_FETCH_WAIT);
    chk("post_rst_cycle1", CycleCount, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Multi-cycle fetch/execute sequencer for the MU0 datapath.
- Drives the enables of the 12-bit PC, IR and 16-bit ACC registers directly upstream, plus the address/ALU muxes and the memory handshake.
- Also keeps cycle and instruction counters for debug visibility.

Parameters:
- MAX_WAIT, 15, maximum cycles MemReq may remain asserted without MemAck before FAULT (1..255)
- CNT_W, 16, width of CycleCount and InstrCount

Ports:
- Clk  input  1  system clock, rising edge
- nReset  input  1  asynchronous, active-low reset
- F  input  4  opcode, IR[15:12]
- N  input  1  ACC negative flag (ACC[15])
- Z  input  1  ACC zero flag
- MemAck  input  1  memory completes the current access this cycle
- MemReq  output  1  memory access request
- Rd  output  1  read strobe, valid with MemReq
- Wr  output  1  write strobe, valid with MemReq
- ASel  output  1  address mux: 0=PC, 1=IR[11:0]
- XSel  output  1  ALU X: 0=ACC, 1=PC
- YSel  output  1  ALU Y: 0=memory data, 1=IR
- AluFn  output  2  ALU_Y, ALU_ADD, ALU_SUB, ALU_INC
- PC_En  output  1  PC register load enable
- IR_En  output  1  IR register load enable
- ACC_En  output  1  ACC register load enable
- Halted  output  1  STP executed
- Fault  output  1  illegal opcode or memory timeout
- CycleCount  output  CNT_W  cycles spent in FETCH/EXEC, saturating
- InstrCount  output  CNT_W  completed instructions, saturating

Behaviour:
- Reset: the one clock is Clk; reset is nReset, asynchronous and active-low. On reset: state FETCH, wait counter 0, counters 0, Halted=0, Fault=0.
- Reset mid-access abandons the access; all enables drop the same instant, since they are combinational from state.
- States: FETCH, EXEC, HALT, FAULT. Registered state; all outputs other than the counters and flags are Moore/Mealy combinational from state, F, N, Z and MemAck.
- FETCH:
  - Drive MemReq=1, Rd=1, ASel=0, XSel=1, AluFn=ALU_INC.
  - PC_En and IR_En assert only in the cycle MemAck=1; then go to EXEC.
  - Minimum fetch latency is 1 cycle (MemAck in the first cycle).
- EXEC, by F:
  - 0 LDA: MemReq, Rd, ASel=1, YSel=0, ALU_Y; ACC_En on MemAck.
  - 1 STO: MemReq, Wr, ASel=1; no register enable; done on MemAck.
  - 2 ADD / 3 SUB: as LDA with XSel=0 and ALU_ADD / ALU_SUB.
  - 4 JMP: YSel=1, ALU_Y, PC_En=1; no MemReq; 1 cycle.
  - 5 JGE: as JMP, but PC_En = ~N.
  - 6 JNE: as JMP, but PC_En = ~Z.
  - 7 STP: go to HALT; no enables.
  - 8..F: go to FAULT; no enables, no MemReq.
- Completion: each completed EXEC (MemAck seen, or a 1-cycle op) returns to FETCH and increments InstrCount. STP counts as completed; an illegal opcode does not.
- Wait counter:
  - Clears on entry to each memory phase and increments each cycle MemReq=1 && MemAck=0.
  - On reaching MAX_WAIT, go to FAULT next cycle; no enables are issued.
- MemAck sampled while MemReq=0 is ignored.
- Rd/Wr/ASel/XSel/YSel/AluFn are held stable for the whole request.
- HALT and FAULT are terminal until reset:
  - All enables and MemReq are 0.
  - Halted=1 in HALT; Fault=1 in FAULT.
  - Counters freeze.
- CycleCount increments every cycle in FETCH or EXEC and saturates at all-ones. InstrCount also saturates; neither wraps.
- Unused select outputs default to 0 in every state.

Decomposition:
- Package mu0_pkg holds:
  - opcode_t enum: LDA..STP, 4 bits
  - alu_fn_t enum: 2 bits
  - state_t enum: FETCH/EXEC/HALT/FAULT
  - OP_ILLEGAL_MIN = 4'h8
- Sub-module mu0_ctrl_decode: combinational opcode-to-control-vector decode for EXEC, with inputs F, N, Z, MemAck. The top level keeps the FSM, wait counter and counters.

Test Plan:
- Reset, then program LDA 0x010 / ADD 0x011 / STO 0x012 / STP with MemAck tied 1 -> sequence FETCH/EXEC ×4; PC_En+IR_En pulse in each fetch; ACC_En in LDA and ADD; Wr in STO; Halted=1; InstrCount=4; CycleCount=8.
- JGE with N=1, then with N=0; JNE with Z=1, then with Z=0 -> PC_En=0, 1, 0, 1 respectively; each EXEC lasts 1 cycle with MemReq=0.
- MemAck delayed 3 cycles on an LDA execute -> MemReq/Rd/ASel=1 held for 4 cycles; ACC_En asserts only in the 4th; CycleCount advances by 4 during that EXEC.
- MemAck never asserted, MAX_WAIT=15 -> FAULT after 15 waiting cycles; Fault=1; no enable ever pulsed; counters frozen.
- Opcode 0xA fetched -> FAULT from EXEC; InstrCount unchanged.
- nReset pulled low mid-fetch wait -> enables and MemReq drop immediately; after release, state is FETCH and counters are 0.
